// File: rtl/splash_pkg.sv
// Shared types for the splash-screen renderer: FSM states, pixel colour and the
// beat that travels through the output FIFO.
package splash_pkg;

    typedef enum logic [1:0] {
        LOAD,
        IDLE,
        RENDER,
        DRAIN
    } state_t;

    typedef logic [23:0] color_t;

    typedef struct packed {
        color_t      color;
        logic [15:0] x;
        logic [15:0] y;
        logic        sof;
        logic        eol;
        logic        eof;
    } pix_beat_t;

    function automatic bit bpp_is_legal(input int bpp);
        return (bpp == 1) || (bpp == 2) || (bpp == 4);
    endfunction

endpackage

// File: rtl/splash_pixel_fifo.sv
// Two-entry FIFO of pixel beats between the palette lookup and the compositor.
// The head is stable while nothing pops; flush empties it in one cycle.
module splash_pixel_fifo
    import splash_pkg::*;
(
    input  logic      clk_12,
    input  logic      rst,
    input  logic      flush,
    input  logic      push,
    input  pix_beat_t push_beat,
    input  logic      pop,
    output pix_beat_t head,
    output logic      full,
    output logic      empty
);
    pix_beat_t  mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Only two entries: resetting them keeps pix_* at zero straight out of reset.
    always_ff @(posedge clk_12 or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_beat;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/splash_screen_renderer.sv
// Splash/loading-screen source: reads the palette header on ROM port B, then streams
// WIDTH x HEIGHT paletted pixels from ROM port A to the compositor with valid/ready.
module splash_screen_renderer
    import splash_pkg::*;
#(
    parameter int WIDTH        = 480,
    parameter int HEIGHT       = 272,
    parameter int BPP          = 1,
    parameter int HEADER_BYTES = 64,
    parameter int PAL_OFFSET   = 8,
    parameter int ROM_AW       = 14
) (
    input  logic              clk_12,
    input  logic              rst,
    input  logic              new_frame,
    input  logic              abort,
    input  logic              reload,
    output logic              busy,
    output logic              pix_valid,
    input  logic              pix_ready,
    output color_t            pix_color,
    output logic [15:0]       pix_x,
    output logic [15:0]       pix_y,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic [ROM_AW-1:0] rom_addr_a,
    input  logic [7:0]        rom_data_a,
    output logic [ROM_AW-1:0] rom_addr_b,
    input  logic [7:0]        rom_data_b
);
    localparam int         HC_W        = $clog2(HEADER_BYTES + 1);
    localparam int         PAL_ENTRIES = 2 ** BPP;
    localparam logic [7:0] IDX_MASK    = 8'(PAL_ENTRIES - 1);

    if (!bpp_is_legal(BPP)) begin : g_bad_bpp
        $error("splash_screen_renderer: BPP must be 1, 2 or 4");
    end
    if (HEADER_BYTES < PAL_OFFSET + 3 * PAL_ENTRIES) begin : g_bad_header
        $error("splash_screen_renderer: palette does not fit in the header");
    end

    state_t          state;
    state_t          state_nxt;
    logic [HC_W-1:0] hdr_cnt;
    logic [7:0]      hdr [HEADER_BYTES];
    logic [15:0]     x;
    logic [15:0]     y;
    logic            inflight;
    logic [2:0]      infl_ofs;
    pix_beat_t       infl_beat;
    pix_beat_t       push_beat;
    pix_beat_t       head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_flush;
    logic [1:0]      fifo_occ;
    logic            pop;
    logic            issue;
    logic            last_pix;
    logic            load_done;
    logic [31:0]     pix_idx;
    logic [31:0]     bit_idx;
    logic [7:0]      pal_idx;
    color_t          pal_color;

    assign load_done = (hdr_cnt == HC_W'(HEADER_BYTES));
    assign pix_idx   = 32'(y) * 32'(WIDTH) + 32'(x);
    assign bit_idx   = pix_idx * 32'(BPP);
    assign last_pix  = (x == 16'(WIDTH - 1)) && (y == 16'(HEIGHT - 1));
    assign pop       = pix_valid && pix_ready;
    assign fifo_occ  = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);

    // A beat popped this cycle frees the slot the pixel issued now will land in two cycles later.
    assign issue = (state == RENDER) && !abort
                   && ((3'(fifo_occ) + 3'(inflight)) < (3'd2 + 3'(pop)));

    assign rom_addr_a = (state == RENDER) ? ROM_AW'(32'(HEADER_BYTES) + (bit_idx >> 3)) : '0;
    assign rom_addr_b = ROM_AW'(hdr_cnt);

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
                if (!abort && load_done) state_nxt = IDLE;
            end
            IDLE: begin
                if (abort)          state_nxt = IDLE;
                else if (reload)    state_nxt = LOAD;
                else if (new_frame) state_nxt = RENDER;
            end
            RENDER: begin
                if (abort)                  state_nxt = IDLE;
                else if (issue && last_pix) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (abort || (!inflight && fifo_empty)) state_nxt = IDLE;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_12 or negedge rst) begin
        if (!rst) begin
            state     <= LOAD;
            hdr_cnt   <= '0;
            x         <= '0;
            y         <= '0;
            inflight  <= 1'b0;
            infl_ofs  <= '0;
            infl_beat <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;

            if (state == LOAD && abort) begin
                hdr_cnt <= '0;
            end else if (state == LOAD && !load_done) begin
                hdr_cnt <= hdr_cnt + 1'b1;
            end else if (state == IDLE && !abort && reload) begin
                hdr_cnt <= '0;
            end

            if (issue) begin
                infl_ofs  <= bit_idx[2:0];
                infl_beat <= '{color: '0, x: x, y: y,
                               sof: (x == 16'd0) && (y == 16'd0),
                               eol: (x == 16'(WIDTH - 1)),
                               eof: last_pix};
                if (x == 16'(WIDTH - 1)) begin
                    x <= '0;
                    y <= last_pix ? 16'd0 : y + 16'd1;
                end else begin
                    x <= x + 16'd1;
                end
            end else if (state != RENDER) begin
                x <= '0;
                y <= '0;
            end
        end
    end

    // NOTE: header bytes are plain storage reloaded before any use, so they carry no reset.
    always_ff @(posedge clk_12) begin
        if (state == LOAD) begin
            for (int k = 0; k < HEADER_BYTES; k++) begin
                if (hdr_cnt == HC_W'(k + 1)) hdr[k] <= rom_data_b;
            end
        end
    end

    always_comb begin
        pal_idx   = (rom_data_a >> infl_ofs) & IDX_MASK;
        pal_color = '0;
        for (int i = 0; i < PAL_ENTRIES; i++) begin
            if (pal_idx == 8'(i)) begin
                pal_color = {hdr[PAL_OFFSET + 3*i + 2], hdr[PAL_OFFSET + 3*i + 1], hdr[PAL_OFFSET + 3*i]};
            end
        end
        push_beat       = infl_beat;
        push_beat.color = pal_color;
    end

    assign fifo_flush = abort && (state == RENDER || state == DRAIN);

    splash_pixel_fifo u_fifo (
        .clk_12    (clk_12),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (inflight),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pix_valid = !fifo_empty;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign pix_color = head.color;
    assign pix_x     = head.x;
    assign pix_y     = head.y;
    assign pix_sof   = head.sof;
    assign pix_eol   = head.eol;
    assign pix_eof   = head.eof;

endmodule
